led_multiblink: RTL and testbench

Multi-channel LED driver; parametrised successor to the single-channel blinker. Each of `CHANNELS` outputs runs its own mode (off, on, blink, breathe) and its own divider, set at runtime through a simple write port. Sits between any board clock domain (oscillator or PLL output) and the LED pins, so one instance replaces several fixed blinkers.

---
 rtl/led_pkg.sv | 10 +
 rtl/led_channel.sv | 73 +++++++
 rtl/led_multiblink.sv | 56 +++++
 tb/tb_led_multiblink.sv | 127 ++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding for the multi-channel LED driver.
package led_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_e;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel with divider, mode mux and breathe stepper.
// LED_MULTIBLINK_BREATHE_EN adds the duty/dir stepper and PWM compare.
module led_channel
  import led_pkg::*;
#(
  parameter int              DIV_W   = 27,
  parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(49_999_999)
`ifdef LED_MULTIBLINK_BREATHE_EN
  ,
  parameter int              PWM_W   = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  led_mode_e        cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
`ifdef LED_MULTIBLINK_BREATHE_EN
  input  logic [PWM_W-1:0] pwm_cnt,
`endif
  output logic             led,
  output logic             tick
);
  led_mode_e        mode;
  logic [DIV_W-1:0] div, cnt;
  logic             term, led_nxt;
  assign term = cnt == div;
`ifdef LED_MULTIBLINK_BREATHE_EN
  logic [PWM_W-1:0] duty, duty_nxt;
  logic             dir, dir_nxt, step, flip;
  // At either end of the ramp one tick is spent turning around instead of stepping.
  always_comb begin
    step     = mode == LED_BREATHE && term;
    flip     = step && (dir ? duty == '0 : &duty);
    dir_nxt  = flip ? ~dir : dir;
    duty_nxt = (step && !flip) ? (dir ? duty - 1'b1 : duty + 1'b1) : duty;
    led_nxt  = mode == LED_OFF ? 1'b0 :
               mode == LED_ON  ? 1'b1 :
               mode == LED_BREATHE ? pwm_cnt < duty : led ^ term;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      dir  <= 1'b0;
    end else if (!we) begin
      duty <= duty_nxt;
      dir  <= dir_nxt;
    end
  end
`else
  always_comb begin
    led_nxt = mode == LED_OFF ? 1'b0 : mode == LED_ON ? 1'b1 : led ^ term;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= LED_BLINK;
      div  <= DEF_DIV;
      cnt  <= '0;
      led  <= 1'b0;
      tick <= 1'b0;
    end else if (we) begin
      mode <= cfg_mode;
      div  <= cfg_div;
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= term ? '0 : cnt + 1'b1;
      tick <= term;
      led  <= led_nxt;
    end
  end
endmodule

// File: rtl/led_multiblink.sv
// led_multiblink: CHANNELS independent LED drivers behind a single write port.
// LED_MULTIBLINK_BREATHE_EN enables the shared PWM counter and BREATHE mode.
module led_multiblink
  import led_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter int  DIV_W    = 27,
  parameter int  DEF_DIV  = 49_999_999,
  parameter int  PWM_W    = 8,
  localparam int CH_W     = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] tick
);
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
    $error("led_multiblink: CHANNELS out of range");
  end
  if (PWM_W < 1) begin : g_bad_pwm
    $error("led_multiblink: PWM_W must be positive");
  end
`ifdef LED_MULTIBLINK_BREATHE_EN
  logic [PWM_W-1:0] pwm_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end
`endif
  // Out-of-range cfg_ch matches no channel, so such writes fall on the floor.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DIV_W'(DEF_DIV))
`ifdef LED_MULTIBLINK_BREATHE_EN
      ,
      .PWM_W   (PWM_W)
`endif
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (cfg_we && cfg_ch == CH_W'(i)),
      .cfg_mode (led_mode_e'(cfg_mode)),
      .cfg_div  (cfg_div),
`ifdef LED_MULTIBLINK_BREATHE_EN
      .pwm_cnt  (pwm_cnt),
`endif
      .led      (led[i]),
      .tick     (tick[i])
    );
  end
endmodule

// File: tb/tb_led_multiblink.sv
// tb_led_multiblink: directed checks of led_multiblink with 5 channels, DEF_DIV=3.
// BREATHE ramp checks are built when LED_MULTIBLINK_BREATHE_EN is defined.
module tb_led_multiblink;
  logic       clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] cfg_div = '0;
  logic [4:0] led, tick;
  int checks = 0, failures = 0, edges = 0;
  always #5 clk = ~clk;
  led_multiblink #(.CHANNELS(5), .DIV_W(8), .DEF_DIV(3), .PWM_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_div(cfg_div), .led(led), .tick(tick)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      edges++;
    end
    #1;
  endtask
  task automatic wr(input logic [2:0] ch, input logic [1:0] mode, input logic [7:0] div);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_div = div;
    step(1);
    cfg_we = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_led", led, 5'h00);
    chk("rst_tick", tick, 5'h00);
    @(negedge clk) rst_n = 1'b1;
    edges = 0;
    step(3);
    chk("e3_led", led, 5'h00);
    chk("e3_tick", tick, 5'h00);
    step(1);
    chk("e4_led", led, 5'h1F);
    chk("e4_tick", tick, 5'h1F);
    step(1);
    chk("e5_tick", tick, 5'h00);
    chk("e5_led", led, 5'h1F);
    step(3);
    chk("e8_led", led, 5'h00);
    chk("e8_tick", tick, 5'h1F);
    wr(3'd1, 2'd0, 8'd3);
    wr(3'd2, 2'd1, 8'd3);
    step(1);
    chk("off_on_led", led, 5'h04);
    chk("off_on_tick", tick, 5'h00);
    step(1);
    chk("e12_led", led, 5'h1D);
    chk("e12_tick", tick, 5'h19);
    step(1);
    chk("e13_tick", tick, 5'h02);
    wr(3'd0, 2'd2, 8'd0);
    step(1);
    chk("div0_led_a", led[0], 1'b0);
    chk("div0_tick_a", tick[0], 1'b1);
    step(1);
    chk("div0_led_b", led[0], 1'b1);
    chk("div0_tick_b", tick[0], 1'b1);
    step(1);
    chk("div0_led_c", led[0], 1'b0);
    step(2);
    wr(3'd3, 2'd2, 8'd3);
    chk("wwin_led", led[3], 1'b0);
    chk("wwin_tick", tick[3], 1'b0);
    step(3);
    chk("wwin_led_e23", led[3], 1'b0);
    step(1);
    chk("wwin_led_e24", led[3], 1'b1);
    chk("wwin_tick_e24", tick[3], 1'b1);
    wr(3'd5, 2'd1, 8'd0);
    chk("oor_led_e25", led, 5'h0C);
    step(1);
    chk("oor_led_e26", led, 5'h0D);
    chk("oor_tick_e26", tick, 5'h05);
    step(2);
    chk("oor_led_e28", led, 5'h15);
    chk("oor_tick_e28", tick, 5'h19);
`ifdef LED_MULTIBLINK_BREATHE_EN
    begin
      int duty = 0, dir = 0, exp_led;
      wr(3'd1, 2'd3, 8'd0);
      for (int k = 0; k < 20; k++) begin
        exp_led = (edges % 8) < duty;
        if (dir == 0) begin
          if (duty == 7) dir = 1; else duty++;
        end else begin
          if (duty == 0) dir = 0; else duty--;
        end
        step(1);
        chk("breathe_led", led[1], exp_led[0]);
      end
    end
`else
    wr(3'd1, 2'd3, 8'd1);
    step(2);
    chk("m3_led_e31", led[1], 1'b1);
    chk("m3_tick_e31", tick[1], 1'b1);
    step(1);
    chk("m3_led_e32", led[1], 1'b1);
    step(1);
    chk("m3_led_e33", led[1], 1'b0);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", led, 5'h00);
    chk("arst_tick", tick, 5'h00);
    @(negedge clk) rst_n = 1'b1;
    edges = 0;
    step(3);
    chk("rerst_e3_led", led, 5'h00);
    step(1);
    chk("rerst_e4_led", led, 5'h1F);
    chk("rerst_e4_tick", tick, 5'h1F);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
